call_stack: RTL and testbench



---
 rtl/call_stack_pkg.sv | 19 +
 rtl/call_stack.sv | 130 +++++++++++++
 tb/tb_call_stack.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/call_stack_pkg.sv
// call_stack_pkg
// Shared types for the return-address stack.
//   stack_op_t  : one-field encoding of the decoder's push/pop request, so the
//                 decoder can carry a single field instead of two bits.
//   decode_op() : folds the raw push/pop bits into a stack_op_t.
package call_stack_pkg;

    typedef enum logic [1:0] {
        STACK_NONE = 2'b00,
        STACK_PUSH = 2'b01,
        STACK_POP  = 2'b10,
        STACK_SWAP = 2'b11   // push and pop together: replace the top entry
    } stack_op_t;

    function automatic stack_op_t decode_op(input logic push, input logic pop);
        return stack_op_t'({pop, push});
    endfunction

endpackage

// File: rtl/call_stack.sv
// call_stack
// Hardware return-address stack for CALL/RET. CALL pushes the program
// counter's incremented address; RET reads top_addr in the same cycle it
// asserts pop and jumps there.
// Ports:
//   rst        asynchronous active-high reset (empties the stack, clears flags)
//   clk        rising-edge clock
//   push       CALL executing this cycle, store push_addr
//   pop        RET executing this cycle, discard the top entry
//   push_addr  return address to store
//   top_addr   current top entry, combinational, 0 when empty
//   count      number of valid entries, 0..DEPTH
//   empty      count == 0
//   full       count == DEPTH
//   overflow   sticky: a push was dropped because the stack was full
//   underflow  sticky: a pop was attempted on an empty stack
module call_stack
    import call_stack_pkg::*;
#(
    parameter int A_WIDTH = 8,
    parameter int DEPTH   = 8
) (
    input  logic                     rst,
    input  logic                     clk,
    input  logic                     push,
    input  logic                     pop,
    input  logic [A_WIDTH-1:0]       push_addr,
    output logic [A_WIDTH-1:0]       top_addr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0]      count_reg, count_next;
    logic               overflow_reg, overflow_next;
    logic               underflow_reg, underflow_next;
    logic               wr_en;
    logic [IW-1:0]      wr_idx;
    logic [IW-1:0]      top_idx;
    logic [DEPTH-1:0]   entry_we;
    logic [A_WIDTH-1:0] entry_reg [DEPTH];
    stack_op_t          op;

    assign op = decode_op(push, pop);

    // Index of the top entry; only meaningful while count_reg > 0. With
    // count_reg == DEPTH the result is DEPTH-1, which fits in IW bits.
    assign top_idx = IW'(count_reg - CW'(1));

    always_comb begin
        count_next     = count_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;
        wr_en          = 1'b0;
        wr_idx         = '0;
        unique case (op)
            STACK_PUSH: begin
                if (count_reg < DEPTH_C) begin
                    wr_en      = 1'b1;
                    wr_idx     = IW'(count_reg);   // truncation safe: count < DEPTH
                    count_next = count_reg + CW'(1);
                end else begin
                    // Drop the new address; the oldest frames stay intact.
                    overflow_next = 1'b1;
                end
            end
            STACK_POP: begin
                if (count_reg != '0) begin
                    count_next = count_reg - CW'(1);
                end else begin
                    underflow_next = 1'b1;
                end
            end
            STACK_SWAP: begin
                wr_en = 1'b1;
                if (count_reg != '0) begin
                    // Pop then push in one cycle: overwrite the top in place,
                    // so no overflow is possible even when full.
                    wr_idx = top_idx;
                end else begin
                    // Nothing to pop, but the push still lands.
                    underflow_next = 1'b1;
                    wr_idx         = '0;
                    count_next     = CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // One-hot write enable per entry.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
        assign entry_we[gi] = wr_en && (wr_idx == IW'(gi));
    end

    // Entry storage is not reset: it is never visible while count is 0.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_we[i]) begin
                entry_reg[i] <= push_addr;
            end
        end
    end

    assign top_addr  = (count_reg == '0) ? '0 : entry_reg[top_idx];
    assign count     = count_reg;
    assign empty     = (count_reg == '0);
    assign full      = (count_reg == DEPTH_C);
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_call_stack.sv
// tb_call_stack
// Self-checking bench for call_stack with A_WIDTH=8, DEPTH=4: a table of
// directed vectors, hand-written asynchronous-reset sequences, and a random
// run compared against a queue-based reference model.
module tb_call_stack;
    import call_stack_pkg::*;

    localparam int AW = 8;
    localparam int DP = 4;

    logic          rst = 1'b0;
    logic          clk = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [AW-1:0] push_addr = '0;
    logic [AW-1:0] top_addr;
    logic [2:0]    count;
    logic          empty, full, overflow, underflow;

    int n_checks = 0;
    int n_pass   = 0;

    call_stack #(.A_WIDTH(AW), .DEPTH(DP)) dut (
        .rst       (rst),
        .clk       (clk),
        .push      (push),
        .pop       (pop),
        .push_addr (push_addr),
        .top_addr  (top_addr),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          clr;     // pulse async reset before this operation
        bit          p;
        bit          q;
        logic [7:0]  addr;
        int          e_count;
        logic [7:0]  e_top;
        bit          e_ov;
        bit          e_un;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_state(input string tag, input int e_count, input int e_top,
                             input bit e_ov, input bit e_un);
        chk({tag, " count"},     int'(count),     e_count);
        chk({tag, " top_addr"},  int'(top_addr),  e_top);
        chk({tag, " empty"},     int'(empty),     int'(e_count == 0));
        chk({tag, " full"},      int'(full),      int'(e_count == DP));
        chk({tag, " overflow"},  int'(overflow),  int'(e_ov));
        chk({tag, " underflow"}, int'(underflow), int'(e_un));
        $display("[%0t] %s: push=%0b pop=%0b count=%0d top=0x%02h ov=%0b un=%0b",
                 $time, tag, push, pop, count, top_addr, overflow, underflow);
    endtask

    // Applies inputs after an edge, lets the next edge take them, then
    // returns 1 time unit after that edge for sampling.
    task automatic step(input bit p, input bit q, input logic [7:0] a);
        push = p; pop = q; push_addr = a;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0;
    endtask

    // Reset pulse well clear of any clock edge.
    task automatic pulse_reset();
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        #1;
    endtask

    // Reference model: a plain queue of return addresses.
    logic [7:0] model_q[$];
    bit         model_ov, model_un;

    task automatic model_reset();
        model_q.delete();
        model_ov = 0;
        model_un = 0;
    endtask

    task automatic model_apply(input bit p, input bit q, input logic [7:0] a);
        if (p && q) begin
            if (model_q.size() == 0) begin
                model_un = 1;
                model_q.push_back(a);
            end else begin
                void'(model_q.pop_back());
                model_q.push_back(a);
            end
        end else if (p) begin
            if (model_q.size() == DP) model_ov = 1;
            else model_q.push_back(a);
        end else if (q) begin
            if (model_q.size() == 0) model_un = 1;
            else void'(model_q.pop_back());
        end
    endtask

    function automatic int model_top();
        return (model_q.size() == 0) ? 0 : int'(model_q[model_q.size()-1]);
    endfunction

    vec_t vecs[$];

    initial begin
        // Reset with no clock edge involved (first posedge is at t=5).
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk_state("reset_idle", 0, 8'h00, 0, 0);

        // clr, push, pop, addr, count, top, ov, un
        vecs = '{
            '{0,1,0,8'h11, 1,8'h11,0,0},
            '{0,1,0,8'h22, 2,8'h22,0,0},
            '{0,1,0,8'h33, 3,8'h33,0,0},
            '{0,0,1,8'h00, 2,8'h22,0,0},
            '{0,0,1,8'h00, 1,8'h11,0,0},
            '{0,0,1,8'h00, 0,8'h00,0,0},
            '{0,1,0,8'h01, 1,8'h01,0,0},
            '{0,1,0,8'h02, 2,8'h02,0,0},
            '{0,1,0,8'h03, 3,8'h03,0,0},
            '{0,1,0,8'h04, 4,8'h04,0,0},
            '{0,1,0,8'h05, 4,8'h04,1,0},
            '{0,0,0,8'h00, 4,8'h04,1,0},
            '{0,0,1,8'h00, 3,8'h03,1,0},
            '{0,0,1,8'h00, 2,8'h02,1,0},
            '{0,0,1,8'h00, 1,8'h01,1,0},
            '{0,0,1,8'h00, 0,8'h00,1,0},
            '{1,1,0,8'h10, 1,8'h10,0,0},
            '{0,1,0,8'h20, 2,8'h20,0,0},
            '{0,1,1,8'hAA, 2,8'hAA,0,0},
            '{0,0,1,8'h00, 1,8'h10,0,0},
            '{1,0,1,8'h00, 0,8'h00,0,1},
            '{0,1,1,8'h5C, 1,8'h5C,0,1},
            '{1,1,0,8'hA1, 1,8'hA1,0,0},
            '{0,1,0,8'hA2, 2,8'hA2,0,0},
            '{0,1,0,8'hA3, 3,8'hA3,0,0},
            '{0,1,0,8'hA4, 4,8'hA4,0,0},
            '{0,1,1,8'hB4, 4,8'hB4,0,0},
            '{0,0,1,8'h00, 3,8'hA3,0,0},
            '{0,0,1,8'h00, 2,8'hA2,0,0}
        };
        foreach (vecs[i]) begin
            if (vecs[i].clr) pulse_reset();
            step(vecs[i].p, vecs[i].q, vecs[i].addr);
            chk_state($sformatf("vec%0d", i), vecs[i].e_count, int'(vecs[i].e_top),
                      vecs[i].e_ov, vecs[i].e_un);
        end

        // Async reset between edges clears entries and sticky flags at once.
        pulse_reset();
        step(0, 1, 8'h00);
        step(1, 0, 8'h40);
        step(1, 0, 8'h41);
        chk_state("pre_async_rst", 2, 8'h41, 0, 1);
        #2 rst = 1'b1;
        #1;
        chk_state("async_rst_held", 0, 8'h00, 0, 0);
        rst = 1'b0;
        #1;
        chk_state("async_rst_released", 0, 8'h00, 0, 0);
        step(1, 0, 8'h7F);
        chk_state("push_after_rst", 1, 8'h7F, 0, 0);

        // Randomized run against the queue model, with occasional resets.
        pulse_reset();
        model_reset();
        for (int i = 0; i < 400; i++) begin
            bit p, q;
            logic [7:0] a;
            if ($urandom_range(0, 39) == 0) begin
                pulse_reset();
                model_reset();
            end
            p = ($urandom_range(0, 99) < 55);
            q = ($urandom_range(0, 99) < 45);
            a = 8'($urandom);
            step(p, q, a);
            model_apply(p, q, a);
            chk_state($sformatf("rand%0d", i), model_q.size(), model_top(),
                      model_ov, model_un);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
